pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect controller for the in-order pipeline.
// Define PIPE_CTRL_PERF_EN to add the stall_cnt_o/flush_cnt_o counters.
module pipe_ctrl #(
    parameter int unsigned HOLD_MAX = 255
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic        hold_flag_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ld_use_i,
    input  logic        mem_busy_i,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        hold_ex_mem_o,
    output logic        clear_if_id_o,
    output logic        clear_id_ex_o,
    output logic        clear_ex_mem_o,
    output logic        pc_jump_o,
    output logic [31:0] pc_jump_addr_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
`endif
    output logic        hold_timeout_o
);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_EX_HOLD,
        S_FLUSH
    } state_t;

    localparam logic [15:0] LP_HOLD_MAX = 16'(HOLD_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_hold_cnt;
    logic [15:0] w_hold_cnt_nxt;
    logic [15:0] w_hold_cnt_inc;
    logic        r_lock;
    logic        w_lock_nxt;

    assign w_hold_cnt_inc = r_hold_cnt + 16'd1;

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_hold_cnt <= '0;
            r_lock     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_lock     <= w_lock_nxt;
        end
    end

    always_comb begin
        hold_pc_o      = 1'b0;
        hold_if_id_o   = 1'b0;
        hold_id_ex_o   = 1'b0;
        hold_ex_mem_o  = 1'b0;
        clear_if_id_o  = 1'b0;
        clear_id_ex_o  = 1'b0;
        clear_ex_mem_o = 1'b0;
        pc_jump_o      = 1'b0;
        pc_jump_addr_o = '0;
        hold_timeout_o = 1'b0;
        w_state_nxt    = S_RUN;
        w_hold_cnt_nxt = '0;
        // Lockout persists only while EX keeps requesting the hold
        w_lock_nxt     = r_lock & hold_flag_i;
        if (rst) begin
            w_lock_nxt = 1'b0;
        end else if (mem_busy_i) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            hold_id_ex_o  = 1'b1;
            hold_ex_mem_o = 1'b1;
            w_state_nxt   = S_MEM_WAIT;
        end else if (r_state == S_FLUSH) begin
            clear_if_id_o = 1'b1;
        end else if (hold_flag_i && !r_lock) begin
            if (w_hold_cnt_inc == LP_HOLD_MAX) begin
                hold_timeout_o = 1'b1;
                w_lock_nxt     = 1'b1;
            end else begin
                hold_pc_o      = 1'b1;
                hold_if_id_o   = 1'b1;
                hold_id_ex_o   = 1'b1;
                clear_ex_mem_o = 1'b1;
                w_state_nxt    = S_EX_HOLD;
                w_hold_cnt_nxt = w_hold_cnt_inc;
            end
        end else if (jump_flag_i) begin
            pc_jump_o      = 1'b1;
            pc_jump_addr_o = jump_addr_i;
            clear_if_id_o  = 1'b1;
            clear_id_ex_o  = 1'b1;
            w_state_nxt    = S_FLUSH;
        end else if (ld_use_i) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            clear_id_ex_o = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_hold_any;

    assign w_hold_any = hold_pc_o | hold_if_id_o
                      | hold_id_ex_o | hold_ex_mem_o;

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hold_any && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (pc_jump_o && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
